cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Synthesisable, parametrised CPU execution-trace capture for on-target debug. It samples one trace word per executed instruction (PC, opcode, flags, mode) into a circular RAM, runs pre- and post-trigger capture around a halt or trap event, and freezes. The captured history is read back in oldest-first order. It sits beside the CPU in `top`, fed by the CPU's EXECUTE strobe. The debug port or the simulation bench reads it after a halt.

## Interface
Parameters:
- `ADDR_W`, 6: log2 of buffer depth; DEPTH = 2**ADDR_W entries.
- `DATA_W`, 40: trace word width. Default packing is {pc[15:0], op[15:0], N,Z,C,V,I,S, 2'b0}.
- `POST_TRIG`, 8: samples captured after the trigger, 0..DEPTH-1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `arm`  in  1  pulse; clears capture state and starts capturing.
- `mode`  in  1  0 = wrap (keep most recent), 1 = one-shot (stop when full). Sampled on `arm`.
- `sample_valid`  in  1  one instruction executed this cycle.
- `sample_data`  in  DATA_W  trace word.
- `trigger`  in  1  halt/trap event.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  logical index, 0 = oldest captured entry.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  `rd_data` holds an in-range entry.
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- `count`  out  ADDR_W+1  valid entries, saturates at DEPTH.
- `trig_pos`  out  ADDR_W+1  logical index of the first post-trigger entry. Equals `count` if no trigger has occurred.
- `overflow`  out  1  wrap mode discarded at least one entry.
- `done`  out  1  `state == DONE`.

## Operation
- Storage is a DEPTH x DATA_W RAM plus `wr_ptr` (ADDR_W bits, wraps modulo DEPTH), `count`, `post_left`, `post_cnt` and a latched mode bit.
- **IDLE:** no writes. `trigger` is ignored. `arm` moves to ARMED.
- **arm (any state):** `wr_ptr`, `count`, `post_cnt` and `overflow` are cleared, `mode` is latched, and the state becomes ARMED. `arm` has priority over a same-cycle `sample_valid` and `trigger`; that sample is not written.
- **Write rule (ARMED or POST):**
  - `sample_valid` writes `sample_data` at `wr_ptr` and increments `wr_ptr`.
  - `count` increments up to DEPTH.
  - A write while `count == DEPTH` sets `overflow` (wrap mode only).
- **ARMED:**
  - `trigger` moves to POST and loads `post_left = POST_TRIG`. If POST_TRIG == 0, it moves straight to DONE.
  - A sample arriving in the same cycle as `trigger` is written and counts as a pre-trigger sample.
  - In one-shot mode, the write that makes `count == DEPTH` moves to DONE.
- **POST:**
  - Each write decrements `post_left` and increments `post_cnt`.
  - The write with `post_left == 1` moves to DONE.
  - In one-shot mode, reaching full also moves to DONE.
  - `trigger` is ignored.
- **DONE:** no writes; `sample_valid` and `trigger` are ignored. Only `arm` leaves DONE.
- **Read address mapping:**
  - Physical address = (`count == DEPTH` ? `wr_ptr` : 0) + `rd_addr`, modulo DEPTH.
  - Reads are legal in every state. Reads taken while capturing see a moving window.
- `trig_pos = count - post_cnt` (ADDR_W+1 bits, unsigned).

## Timing
- **Reset (`rst_n` low at a clk edge):**
  - state = IDLE; `count`, `trig_pos`, `overflow`, `done`, `rd_valid` = 0; `rd_data` = 0.
  - RAM contents are not cleared.
  - Reset mid-capture abandons the capture; a later read returns `rd_valid` = 0 until new entries exist.
- **Write latency:** a sample accepted at edge N is readable by a read issued at edge N+1.
- **Read latency:** 1 cycle. `rd_en` at edge N gives `rd_data` and `rd_valid` after edge N+1.
  - `rd_valid` = delayed (`rd_en` && `rd_addr < count`).
  - When `rd_valid` is 0, `rd_data` = 0.
  - Without `rd_en`, `rd_valid` drops to 0 and `rd_data` holds its value.
- **Status timing:** `state`, `count`, `overflow` and `done` are registered and update on the edge that accepts the causing event.
- **Throughput:** one sample per cycle is sustained with no backpressure.

## Test plan
Bench parameters: ADDR_W=3 (DEPTH 8), POST_TRIG=2.
- Reset, then read `rd_addr`=0 → `rd_valid`=0, `rd_data`=0, state=0, `count`=0.
- Wrap mode, arm, 12 samples 0x01..0x0C, trigger with sample 0x0D, then samples 0x0E, 0x0F, 0x10 → state=DONE after 0x0F; `count`=8; `overflow`=1; `trig_pos`=6; reads 0..7 return 0x08..0x0F; 0x10 is not stored.
- One-shot mode, arm, 10 samples 0x21..0x2A with no trigger → DONE after the 8th; reads 0..7 return 0x21..0x28; `overflow`=0; `trig_pos`=8.
- Wrap mode, arm, 3 samples, trigger, 2 samples → `count`=5, `trig_pos`=3; read `rd_addr`=5 → `rd_valid`=0.
- Same cycle `arm` + `sample_valid` + `trigger` while in DONE → state=ARMED, `count`=0, nothing written.
- Drive `rst_n` low while in POST with `count`=4 → next cycle state=IDLE, `count`=0; subsequent `sample_valid` pulses are ignored until `arm`.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// Bundle of trace-capture, read-back and status signals between a CPU/debug
// host (master) and the trace buffer (slave).
interface cpu_trace_buffer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 40
);
    logic              arm;
    logic              mode;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              trigger;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   trig_pos;
    logic              overflow;
    logic              done;

    modport master (
        output arm, mode, sample_valid, sample_data, trigger, rd_en, rd_addr,
        input  rd_data, rd_valid, state, count, trig_pos, overflow, done
    );

    modport slave (
        input  arm, mode, sample_valid, sample_data, trigger, rd_en, rd_addr,
        output rd_data, rd_valid, state, count, trig_pos, overflow, done
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular execution-trace capture with pre/post-trigger windowing and
// oldest-first registered read-back.
module cpu_trace_buffer #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 40,
    parameter int POST_TRIG = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_trace_buffer_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   FULL_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = CNT_ONE[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] POST_C  = POST_TRIG[ADDR_W-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic [ADDR_W-1:0] post_left_q, post_left_d;
    logic [ADDR_W:0]   post_cnt_q,  post_cnt_d;
    logic              mode_q,      mode_d;
    logic              overflow_q,  overflow_d;
    logic [ADDR_W:0]   trig_pos_q,  trig_pos_d;
    logic              done_q,      done_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;

    logic              wr_en_s;
    logic              full_s;
    logic [ADDR_W-1:0] rd_phys_s;

    // Next-state computation for capture FSM, counters and read port.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_left_d = post_left_q;
        post_cnt_d  = post_cnt_q;
        mode_d      = mode_q;
        overflow_d  = overflow_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        full_s  = (count_q == FULL_C);
        wr_en_s = rst_n && !bus.arm && bus.sample_valid &&
                  ((state_q == ST_ARMED) || (state_q == ST_POST));

        // Once full, the oldest entry sits at the write pointer.
        rd_phys_s = (full_s ? wr_ptr_q : {ADDR_W{1'b0}}) + bus.rd_addr;
        if (bus.rd_en) begin
            rd_valid_d = ({1'b0, bus.rd_addr} < count_q);
            if (rd_valid_d) begin
                rd_data_d = mem_q[rd_phys_s];
            end else begin
                rd_data_d = {DATA_W{1'b0}};
            end
        end else begin
            rd_valid_d = 1'b0;
        end

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (full_s) begin
                overflow_d = overflow_q | ~mode_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (bus.arm) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = {ADDR_W{1'b0}};
            count_d     = {(ADDR_W+1){1'b0}};
            post_left_d = {ADDR_W{1'b0}};
            post_cnt_d  = {(ADDR_W+1){1'b0}};
            overflow_d  = 1'b0;
            mode_d      = bus.mode;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    // A same-cycle sample is pre-trigger; a full one-shot buffer wins.
                    if (mode_q && (count_d == FULL_C)) begin
                        state_d = ST_DONE;
                    end else if (bus.trigger) begin
                        post_left_d = POST_C;
                        if (POST_TRIG == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (wr_en_s) begin
                        post_left_d = post_left_q - PTR_ONE;
                        post_cnt_d  = post_cnt_q + CNT_ONE;
                        if ((post_left_q == PTR_ONE) || (mode_q && (count_d == FULL_C))) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        state_d = ST_POST;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        done_d     = (state_d == ST_DONE);
        trig_pos_d = count_d - post_cnt_d;
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= {(ADDR_W+1){1'b0}};
            post_left_q <= {ADDR_W{1'b0}};
            post_cnt_q  <= {(ADDR_W+1){1'b0}};
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            trig_pos_q  <= {(ADDR_W+1){1'b0}};
            done_q      <= 1'b0;
            rd_data_q   <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_left_q <= post_left_d;
            post_cnt_q  <= post_cnt_d;
            mode_q      <= mode_d;
            overflow_q  <= overflow_d;
            trig_pos_q  <= trig_pos_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Trace RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.sample_data;
        end
    end

    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.trig_pos = trig_pos_q;
    assign bus.overflow = overflow_q;
    assign bus.done     = done_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: a vector table for the wrap-mode
// trigger scenario plus hand-written multi-cycle sequences.
module tb_cpu_trace_buffer;
    localparam int AW = 3;
    localparam int DW = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cpu_trace_buffer #(.ADDR_W(AW), .DATA_W(DW), .POST_TRIG(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          arm;
        logic          mode;
        logic          sv;
        logic          trig;
        logic [DW-1:0] data;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic [1:0]    exp_state;
        logic [AW:0]   exp_count;
        logic [AW:0]   exp_trig;
        logic          exp_ovf;
        logic          chk_rd;
        logic          exp_rv;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int a, input int m, input int sv, input int tr,
                                input int d, input int re, input int ra,
                                input int st, input int cnt, input int tp, input int ov,
                                input int cr, input int rv, input int rd);
        vec_t v;
        v.arm = 1'(a); v.mode = 1'(m); v.sv = 1'(sv); v.trig = 1'(tr);
        v.data = 40'(d); v.rd_en = 1'(re); v.rd_addr = 3'(ra);
        v.exp_state = 2'(st); v.exp_count = 4'(cnt); v.exp_trig = 4'(tp);
        v.exp_ovf = 1'(ov); v.chk_rd = 1'(cr); v.exp_rv = 1'(rv); v.exp_rd = 40'(rd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic m, input logic sv, input logic tr,
                         input logic [DW-1:0] d, input logic re, input logic [AW-1:0] ra);
        bus.arm = a; bus.mode = m; bus.sample_valid = sv; bus.trigger = tr;
        bus.sample_data = d; bus.rd_en = re; bus.rd_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string n, input logic [1:0] st, input logic [AW:0] cnt,
                              input logic [AW:0] tp, input logic ov);
        chk({n, ".state"},    64'(bus.state),    64'(st));
        chk({n, ".count"},    64'(bus.count),    64'(cnt));
        chk({n, ".trig_pos"}, 64'(bus.trig_pos), 64'(tp));
        chk({n, ".overflow"}, 64'(bus.overflow), 64'(ov));
        chk({n, ".done"},     64'(bus.done),     64'(st == 2'd3));
    endtask

    task automatic chk_read(input string n, input logic rv, input logic [DW-1:0] rd);
        chk({n, ".rd_valid"}, 64'(bus.rd_valid), 64'(rv));
        chk({n, ".rd_data"},  64'(bus.rd_data),  64'(rd));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Wrap mode: 12 samples, trigger with 0x0D, then 0x0E, 0x0F, 0x10 (ignored).
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 12; i++) begin
            vecs.push_back(mk(0, 0, 1, 0, i, 0, 0, 1, (i > 8) ? 8 : i, (i > 8) ? 8 : i,
                              (i > 8) ? 1 : 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 1, 1, 'h0D, 0, 0, 2, 8, 8, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h0E, 0, 0, 2, 8, 7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 'h0F, 0, 0, 3, 8, 6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 'h10, 0, 0, 3, 8, 6, 1, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 1, k, 3, 8, 6, 1, 1, 1, 'h08 + k));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 8, 6, 1, 1, 0, 'h0F));

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b0, 3'd0);
        tick();
        tick();
        chk_status("reset", 2'd0, 4'd0, 4'd0, 1'b0);
        chk_read("reset", 1'b0, 40'h0);

        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'd0);
        tick();
        chk_read("post_reset_rd", 1'b0, 40'h0);
        chk_status("post_reset", 2'd0, 4'd0, 4'd0, 1'b0);

        drive(1'b0, 1'b0, 1'b1, 1'b1, 40'h55, 1'b0, 3'd0);
        tick();
        tick();
        chk_status("idle_ignore", 2'd0, 4'd0, 4'd0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].arm, vecs[i].mode, vecs[i].sv, vecs[i].trig,
                  vecs[i].data, vecs[i].rd_en, vecs[i].rd_addr);
            tick();
            chk_status($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_count,
                       vecs[i].exp_trig, vecs[i].exp_ovf);
            if (vecs[i].chk_rd) begin
                chk_read($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_rd);
            end
        end

        // arm beats same-cycle sample and trigger while DONE.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 40'hAA, 1'b0, 3'd0);
        tick();
        chk_status("arm_prio", 2'd1, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'd0);
        tick();
        chk_read("arm_prio_rd", 1'b0, 40'h0);
        chk_status("arm_prio_hold", 2'd1, 4'd0, 4'd0, 1'b0);

        // One-shot: stops after the eighth sample.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 40'h0, 1'b0, 3'd0);
        tick();
        chk_status("os_arm", 2'd1, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            logic [AW:0] c;
            c = (k + 1 > 8) ? 4'd8 : 4'(k + 1);
            drive(1'b0, 1'b0, 1'b1, 1'b0, 40'h21 + 40'(k), 1'b0, 3'd0);
            tick();
            chk_status($sformatf("os_s%0d", k), (k >= 7) ? 2'd3 : 2'd1, c, c, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'(k));
            tick();
            chk_read($sformatf("os_rd%0d", k), 1'b1, 40'h21 + 40'(k));
        end

        // Wrap: 3 samples, bare trigger, 2 post samples.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 40'h0, 1'b0, 3'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 40'h31 + 40'(k), 1'b0, 3'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 40'h0, 1'b0, 3'd0);
        tick();
        chk_status("short_trig", 2'd2, 4'd3, 4'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 40'h34, 1'b0, 3'd0);
        tick();
        chk_status("short_p1", 2'd2, 4'd4, 4'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 40'h35, 1'b0, 3'd0);
        tick();
        chk_status("short_p2", 2'd3, 4'd5, 4'd3, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'd5);
        tick();
        chk_read("short_rd5", 1'b0, 40'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'd3);
        tick();
        chk_read("short_rd3", 1'b1, 40'h34);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'd0);
        tick();
        chk_read("short_rd0", 1'b1, 40'h31);

        // Reset in POST with four entries captured.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 40'h0, 1'b0, 3'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, (k == 3) ? 1'b1 : 1'b0, 40'h41 + 40'(k), 1'b0, 3'd0);
            tick();
        end
        chk_status("rst_pre", 2'd2, 4'd4, 4'd4, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b0, 3'd0);
        tick();
        chk_status("rst_mid", 2'd0, 4'd0, 4'd0, 1'b0);
        chk_read("rst_mid", 1'b0, 40'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 40'h99, 1'b0, 3'd0);
            tick();
        end
        chk_status("rst_ignore", 2'd0, 4'd0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 1'b1, 3'd0);
        tick();
        chk_read("rst_rd", 1'b0, 40'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 40'h0, 1'b0, 3'd0);
        tick();
        chk_status("rst_rearm", 2'd1, 4'd0, 4'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
